// File: rtl/vid_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vid_timing
//  Purpose  : Raster timing generator (640x480@60 by default). Produces the
//             pixel coordinates, active-video and sync strobes, plus a
//             once-per-frame pulse and a wrapping frame counter.
//
//  Ports    : clk          pixel clock
//             rst          synchronous active-high reset
//             ce           pixel enable; all state holds when low
//             x, y         registered raster position (not clamped in blanking)
//             de           active-video strobe (delayed by PIPE_DELAY)
//             hsync, vsync sync strobes at level SYNC_POL (delayed by PIPE_DELAY)
//             frame_start  one-ce pulse when x=0, y=0 is presented
//             frame_count  frames started since reset (wraps at 65535)
//
//  Revision : 1.0 - initial release
// ============================================================================
module vid_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vid_timing: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
            $error("vid_timing: PIPE_DELAY must be in 0..7");
        end
    endgenerate

    // Thresholds are 11 bits wide: with a 1024 total an end bound equals 1024
    // and would alias to 0 in a 10-bit compare.
    localparam logic [9:0]  c_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        c_SYNC_OFF = !SYNC_POL;
    // Delay-line stage layout: {de, hsync, vsync}
    localparam logic [2:0]  c_STAGE_RST = {1'b0, c_SYNC_OFF, c_SYNC_OFF};

    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        fs_q, fs_d;
    logic [15:0] fc_q, fc_d;
    // Stage 0 is the output register; stages 1..PIPE_DELAY are the extra delay.
    logic [2:0]  stage_q [PIPE_DELAY+1];
    logic [2:0]  stage_d [PIPE_DELAY+1];

    logic [10:0] w_h_ext, w_v_ext;
    logic        w_de, w_hs, w_vs, w_origin;

    assign w_h_ext  = {1'b0, h_q};
    assign w_v_ext  = {1'b0, v_q};
    assign w_de     = (w_h_ext < c_H_ACT) && (w_v_ext < c_V_ACT);
    assign w_hs     = (w_h_ext >= c_HS_BEG) && (w_h_ext < c_HS_END);
    assign w_vs     = (w_v_ext >= c_VS_BEG) && (w_v_ext < c_VS_END);
    assign w_origin = (h_q == 10'd0) && (v_q == 10'd0);

    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        x_d     = x_q;
        y_d     = y_q;
        fs_d    = 1'b0;     // a stalled ce must never stretch the pulse
        fc_d    = fc_q;
        stage_d = stage_q;
        if (ce) begin
            if (h_q == c_H_LAST) begin
                h_d = 10'd0;
                v_d = (v_q == c_V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            x_d  = h_q;
            y_d  = v_q;
            fs_d = w_origin;
            // Counter moves with the pulse so both are presented together.
            if (w_origin) begin
                fc_d = fc_q + 16'd1;
            end
            stage_d[0] = {w_de,
                          w_hs ? SYNC_POL : c_SYNC_OFF,
                          w_vs ? SYNC_POL : c_SYNC_OFF};
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q  <= 10'd0;
            v_q  <= 10'd0;
            x_q  <= 10'd0;
            y_q  <= 10'd0;
            fs_q <= 1'b0;
            fc_q <= 16'd0;
            for (int i = 0; i <= PIPE_DELAY; i++) begin
                stage_q[i] <= c_STAGE_RST;
            end
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
            stage_q <= stage_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = stage_q[PIPE_DELAY][2];
    assign hsync       = stage_q[PIPE_DELAY][1];
    assign vsync       = stage_q[PIPE_DELAY][0];
    assign frame_start = fs_q;
    assign frame_count = fc_q;

endmodule
`default_nettype wire

// File: tb/tb_vid_timing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vid_timing
//  Purpose  : Self-checking bench for vid_timing. Three instances share the
//             stimulus: A (default timing, no delay), B (default timing,
//             PIPE_DELAY=2) and C (small raster, active-high sync) so that
//             whole frames fit in a short run. A reference model derives every
//             output from the count of ce edges since reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vid_timing;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] fc;
    } out_t;

    typedef struct {
        bit rst; bit ce; int x; int y; bit de; bit hs; bit fs; int fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    logic [9:0]  a_x, a_y, b_x, b_y, c_x, c_y;
    logic        a_de, a_hs, a_vs, a_fs, b_de, b_hs, b_vs, b_fs;
    logic        c_de, c_hs, c_vs, c_fs;
    logic [15:0] a_fc, b_fc, c_fc;
    out_t        oa, ob, oc;

    int     n_checks = 0;
    int     n_errs   = 0;
    bit     run_chk  = 1'b0;
    longint mn       = 0;       // ce edges since reset
    bit     mlce     = 1'b0;    // last edge carried ce=1 without reset

    vec_t tbl [10];
    int   de_cnt, hs_cnt, hs_min, hs_max, b_de_x, b_hs_x;
    bit   wrapped, found;
    logic [9:0] px, py;
    int   pulses [3];
    int   np, vs_cnt, de_bad;

    always #5 clk = ~clk;

    vid_timing #(.PIPE_DELAY(0)) u_a (
        .clk(clk), .rst(rst), .ce(ce), .x(a_x), .y(a_y), .de(a_de),
        .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs), .frame_count(a_fc));

    vid_timing #(.PIPE_DELAY(2)) u_b (
        .clk(clk), .rst(rst), .ce(ce), .x(b_x), .y(b_y), .de(b_de),
        .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs), .frame_count(b_fc));

    vid_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .PIPE_DELAY(0)
    ) u_c (
        .clk(clk), .rst(rst), .ce(ce), .x(c_x), .y(c_y), .de(c_de),
        .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs), .frame_count(c_fc));

    assign oa = {a_x, a_y, a_de, a_hs, a_vs, a_fs, a_fc};
    assign ob = {b_x, b_y, b_de, b_hs, b_vs, b_fs, b_fc};
    assign oc = {c_x, c_y, c_de, c_hs, c_vs, c_fs, c_fc};

    // Output n ce-edges after reset shows raster position n-1; the strobes
    // show position n-1-pd. frame_count counts frames entered so far.
    function automatic out_t model(input int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, pd,
                                   input bit pol, input longint n, input bit lce);
        out_t   o;
        longint ht, vt, ft, p, q;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        ft = ht * vt;
        o.x = '0; o.y = '0; o.de = 1'b0; o.hs = ~pol; o.vs = ~pol;
        o.fs = 1'b0; o.fc = '0;
        if (n > 0) begin
            p    = (n - 1) % ft;
            o.x  = 10'(p % ht);
            o.y  = 10'(p / ht);
            o.fc = 16'(((n - 1) / ft + 1) % 65536);
            o.fs = lce && (p == 0);
            q    = n - 1 - pd;
            if (q >= 0) begin
                q    = q % ft;
                o.de = ((q % ht) < ha) && ((q / ht) < va);
                o.hs = ((q % ht) >= ha + hfp && (q % ht) < ha + hfp + hsw) ? pol : ~pol;
                o.vs = ((q / ht) >= va + vfp && (q / ht) < va + vfp + vsw) ? pol : ~pol;
            end
        end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            if (n_errs <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input out_t a, input out_t e);
        chk({tag, ".x"},  32'(a.x),  32'(e.x));
        chk({tag, ".y"},  32'(a.y),  32'(e.y));
        chk({tag, ".de"}, 32'(a.de), 32'(e.de));
        chk({tag, ".hs"}, 32'(a.hs), 32'(e.hs));
        chk({tag, ".vs"}, 32'(a.vs), 32'(e.vs));
        chk({tag, ".fs"}, 32'(a.fs), 32'(e.fs));
        chk({tag, ".fc"}, 32'(a.fc), 32'(e.fc));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model state
    always @(posedge clk) begin
        if (rst) begin
            mn   <= 0;
            mlce <= 1'b0;
        end else if (ce) begin
            mn   <= mn + 1;
            mlce <= 1'b1;
        end else begin
            mlce <= 1'b0;
        end
    end

    // Every cycle, all three instances against the model
    always @(negedge clk) begin
        if (run_chk) begin
            chk_out("A", oa, model(640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b0, mn, mlce));
            chk_out("B", ob, model(640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, mn, mlce));
            chk_out("C", oc, model(16, 2, 3, 3, 6, 2, 2, 2, 0, 1'b1, mn, mlce));
        end
    end

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        //            rst ce  x  y  de hs fs fc
        tbl[0] = '{1, 1, 0, 0, 0, 1, 0, 0};
        tbl[1] = '{0, 1, 0, 0, 1, 1, 1, 1};
        tbl[2] = '{0, 1, 1, 0, 1, 1, 0, 1};
        tbl[3] = '{0, 0, 1, 0, 1, 1, 0, 1};
        tbl[4] = '{0, 1, 2, 0, 1, 1, 0, 1};
        tbl[5] = '{1, 0, 0, 0, 0, 1, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 1, 0, 0};
        tbl[7] = '{0, 1, 0, 0, 1, 1, 1, 1};
        tbl[8] = '{1, 1, 0, 0, 0, 1, 0, 0};
        tbl[9] = '{0, 1, 0, 0, 1, 1, 1, 1};

        @(negedge clk);
        run_chk = 1'b1;

        // ---- table vectors on instance A ----
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst;
            ce  = tbl[i].ce;
            @(negedge clk);
            chk($sformatf("tbl%0d.x", i),  32'(a_x),  tbl[i].x);
            chk($sformatf("tbl%0d.y", i),  32'(a_y),  tbl[i].y);
            chk($sformatf("tbl%0d.de", i), 32'(a_de), 32'(tbl[i].de));
            chk($sformatf("tbl%0d.hs", i), 32'(a_hs), 32'(tbl[i].hs));
            chk($sformatf("tbl%0d.fs", i), 32'(a_fs), 32'(tbl[i].fs));
            chk($sformatf("tbl%0d.fc", i), 32'(a_fc), tbl[i].fc);
        end

        // ---- one full line: A (no delay) and B (delay 2) ----
        do_reset();
        ce = 1'b1;
        de_cnt = 0; hs_cnt = 0; hs_min = 1023; hs_max = 0;
        b_de_x = -1; b_hs_x = -1; wrapped = 1'b0; px = '0; py = '0;
        for (int i = 0; i < 801; i++) begin
            @(negedge clk);
            if (a_y == 10'd0) begin
                if (a_de) de_cnt++;
                if (!a_hs) begin
                    hs_cnt++;
                    if (int'(a_x) < hs_min) hs_min = int'(a_x);
                    if (int'(a_x) > hs_max) hs_max = int'(a_x);
                end
            end
            if (i > 0 && px == 10'd799 && a_x == 10'd0) begin
                wrapped = 1'b1;
                chk("line.wrap_y", 32'(a_y), 1);
                chk("line.prev_y", 32'(py), 0);
            end
            if (b_de && b_de_x < 0) b_de_x = int'(b_x);
            if (!b_hs && b_hs_x < 0) b_hs_x = int'(b_x);
            px = a_x;
            py = a_y;
        end
        chk("line.de_cycles", de_cnt, 640);
        chk("line.hs_cycles", hs_cnt, 96);
        chk("line.hs_first_x", hs_min, 656);
        chk("line.hs_last_x", hs_max, 751);
        chk("line.wrapped", 32'(wrapped), 1);
        chk("delay.de_rise_x", b_de_x, 2);
        chk("delay.hs_fall_x", b_hs_x, 658);

        // ---- whole frames on C (24 x 12 = 288 cycles each) ----
        do_reset();
        ce = 1'b1;
        np = 0; vs_cnt = 0; de_bad = 0;
        pulses[0] = 0; pulses[1] = 0; pulses[2] = 0;
        for (int i = 0; i < 3 * 288 + 5; i++) begin
            @(negedge clk);
            if (c_fs) begin
                if (np < 3) pulses[np] = i;
                np++;
                if (np == 3) chk("frame.fc_at_3rd", 32'(c_fc), 3);
            end
            if (np == 1 && c_vs) vs_cnt++;
            if (c_de && c_y >= 10'd6) de_bad++;
        end
        chk("frame.pulses", 32'(np >= 3), 1);
        chk("frame.period1", pulses[1] - pulses[0], 288);
        chk("frame.period2", pulses[2] - pulses[1], 288);
        chk("frame.vs_cycles", vs_cnt, 48);
        chk("frame.de_in_vblank", de_bad, 0);

        // ---- ce stall 1,0,0,1 across the last pixel of a frame on C ----
        do_reset();
        ce = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (c_x == 10'd23 && c_y == 10'd11) found = 1'b1;
        end
        chk("corner.reached", 32'(found), 1);
        if (found) begin
            ce = 1'b0;
            @(negedge clk);
            chk("corner.hold1.x", 32'(c_x), 23);
            chk("corner.hold1.y", 32'(c_y), 11);
            chk("corner.hold1.fs", 32'(c_fs), 0);
            @(negedge clk);
            chk("corner.hold2.x", 32'(c_x), 23);
            chk("corner.hold2.fs", 32'(c_fs), 0);
            ce = 1'b1;
            @(negedge clk);
            chk("corner.wrap.x", 32'(c_x), 0);
            chk("corner.wrap.y", 32'(c_y), 0);
            chk("corner.wrap.fs", 32'(c_fs), 1);
            chk("corner.wrap.fc", 32'(c_fc), 2);
            @(negedge clk);
            chk("corner.after.fs", 32'(c_fs), 0);
            chk("corner.after.x", 32'(c_x), 1);
        end

        // ---- reset mid-frame on A ----
        do_reset();
        ce = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (a_x == 10'd300 && a_y == 10'd2) found = 1'b1;
        end
        chk("midrst.reached", 32'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.x", 32'(a_x), 0);
        chk("midrst.y", 32'(a_y), 0);
        chk("midrst.de", 32'(a_de), 0);
        chk("midrst.fc", 32'(a_fc), 0);
        chk("midrst.hs", 32'(a_hs), 1);
        chk("midrst.vs", 32'(a_vs), 1);
        @(negedge clk);
        chk("midrst.first.de", 32'(a_de), 1);
        chk("midrst.first.fs", 32'(a_fs), 1);
        chk("midrst.first.fc", 32'(a_fc), 1);
        chk("midrst.first.b_de", 32'(b_de), 0);

        // ---- randomized ce / occasional reset, checked by the model ----
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            ce  = ($urandom_range(0, 99) < 80);
            rst = ($urandom_range(0, 2999) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        ce  = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vid_timing.md
# vid_timing

Generates 640x480@60 raster timing for the HDMI output path. Sits directly upstream of the game-of-life renderer: it drives the pixel coordinates the renderer turns into colour, and the blanking/sync strobes the TMDS encoder consumes alongside that colour. It also provides a frame pulse and frame counter so game logic can step once per frame instead of keeping its own free-running divider.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- PIPE_DELAY, 0, extra register stages on de/hsync/vsync relative to x/y, 0..7

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1, pixel clock
- rst, input, 1, synchronous active-high reset
- ce, input, 1, pixel enable; all state holds when low
- x, output, 10, horizontal counter, 0..H_TOTAL-1
- y, output, 10, vertical counter, 0..V_TOTAL-1
- de, output, 1, active-video strobe
- hsync, output, 1, horizontal sync at SYNC_POL
- vsync, output, 1, vertical sync at SYNC_POL
- frame_start, output, 1, one-ce pulse at x=0, y=0
- frame_count, output, 16, frames started since reset

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be at most 1024; this is checked at elaboration.
- Internal counters h and v advance on clk with ce=1:
  - h wraps H_TOTAL-1 -> 0.
  - v increments only on an h wrap, and wraps V_TOTAL-1 -> 0.
- Outputs are registered from h/v with ce=1:
  - x <= h, y <= v.
  - de_i = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs_i asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_i asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), for whole lines.
  - frame_start <= (h==0 && v==0).
  - frame_count increments, wrapping at 65535, in the same cycle frame_start registers 1. It therefore shows the new value together with the pulse.
- Delay line: de/hsync/vsync pass through a PIPE_DELAY-deep shift register that advances only on ce. PIPE_DELAY=0 means no extra stage.
- Hold behaviour with ce=0:
  - counters, output registers and the delay line all hold;
  - frame_start is forced to 0 so that a stalled clock never produces a multi-cycle pulse.
- x/y are not clamped during blanking. Downstream code must qualify them with de.

## Timing
- Reset values: h=v=0, x=0, y=0, de=0, frame_start=0, frame_count=0. hsync and vsync reset to inactive (~SYNC_POL). Every delay-line stage also resets to inactive.
- Reset wins over ce. Asserting rst mid-frame returns to these values on the next edge.
- First ce edge after reset release: x=0, y=0, de=1 (after PIPE_DELAY further ce edges), frame_start=1, frame_count=1.
- Latency:
  - counter to x/y: 1 ce cycle;
  - counter to de/sync: 1+PIPE_DELAY ce cycles.
- Line period: 800 ce cycles. Frame period: 420000 ce cycles.
- Simultaneous h and v wrap (h=799, v=524): the next output is x=0, y=0, frame_start=1.

## Test plan
- Reset, then ce=1 constantly, PIPE_DELAY=0 -> after the first edge x=0, y=0, de=1, frame_start=1, frame_count=1; hsync=vsync=1.
- Run one line -> de high for exactly 640 cycles (x=0..639); hsync low exactly for x=656..751; x goes 799 -> 0 with y 0 -> 1.
- Run full frames -> vsync low only for y=490..491 (1600 cycles); frame_start period is 420000 cycles; frame_count=3 after the third pulse; de is never high for y>=480.
- ce toggling 1,0,0,1 at x=799, y=524 -> outputs hold for 2 cycles; frame_start is 0 during the hold and 1 for exactly one cycle after the wrap.
- PIPE_DELAY=2 -> de/hsync lag x/y by 2 ce cycles: de rises 2 cycles after x=0 appears, and hsync falls when x=658.
- Assert rst for 1 cycle at x=300, y=200 -> next edge gives x=0, y=0, de=0, frame_count=0, syncs inactive; normal sequence restarts as after power-on reset.
